par8_master: RTL and testbench
==============================

Name: par8_master

Overview:
- Master (RPi-side) end of the 8-bit parallel bus: generates bus_clk, drives bus_rnw and bus_data, and samples slave read data and the bus_done/bus_match status lines.
- Used in FPGA-to-FPGA links and as a synthesizable bus exerciser against the par8 receiver/transmitter pair.
- Host side is a single-byte command/response handshake.
- Every byte transfer is one full bus_clk period, paced from clk by a programmable divider.

Parameters:
- CLK_DIV, 4, clk cycles per bus_clk half-period. Minimum 2.
- TURN_CYCLES, 4, idle clk cycles inserted on every bus direction change. Minimum 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- cmd_valid  in  1  host command present
- cmd_rnw  in  1  1 = read one byte from slave, 0 = write cmd_data
- cmd_data  in  8  write byte
- cmd_ready  out  1  command accepted on any clk edge where cmd_valid & cmd_ready
- rd_data  out  8  byte captured on a read
- rd_valid  out  1  one-cycle pulse; rd_data is valid during that cycle
- busy  out  1  high whenever state != IDLE
- bus_clk  out  1  bus strobe
- bus_rnw  out  1  bus direction, master perspective
- bus_data_out  out  8  master write data
- bus_data_oe  out  1  tri-state enable for bus_data_out
- bus_data_in  in  8  slave-driven data
- bus_done  in  1  async status from slave
- bus_match  in  1  async status from slave
- done_sync  out  1  bus_done after 2-flop synchronizer
- match_sync  out  1  bus_match after 2-flop synchronizer
- done_rise  out  1  one-cycle pulse on a 0->1 transition of done_sync

Behaviour:
- Reset values (forced immediately and asynchronously):
  - state=IDLE, bus_clk=0, bus_rnw=0, bus_data_oe=0, bus_data_out=0
  - rd_data=0, rd_valid=0, busy=0, synchronizer flops=0, done_sync=0, match_sync=0, done_rise=0
- All outputs are registered. cmd_ready = (state==IDLE) and is the only combinational output.
- States: IDLE, TURN, LOW, HIGH. One down-counter, wide enough for max(CLK_DIV, TURN_CYCLES).
- IDLE, on accept (edge E0):
  - Latch cmd_rnw and cmd_data.
  - If cmd_rnw == bus_rnw: go to LOW.
  - Otherwise go to TURN.
- TURN:
  - Write->read: bus_data_oe drops to 0 at E0. After TURN_CYCLES cycles, bus_rnw<=1 and go to LOW.
  - Read->write: bus_rnw drops to 0 at E0. After TURN_CYCLES cycles, bus_data_oe<=1 and go to LOW.
  - Total added latency: TURN_CYCLES cycles.
- LOW (CLK_DIV cycles):
  - bus_clk=0.
  - On a write, bus_data_out = latched byte and bus_data_oe=1.
  - bus_clk rises at the last edge of LOW: E0+CLK_DIV when no turnaround.
- HIGH (CLK_DIV cycles):
  - bus_clk=1. Write data is held stable.
  - At the final HIGH edge (E0+2*CLK_DIV with no turnaround): bus_clk<=0 and state<=IDLE.
  - On a read, the same edge samples bus_data_in into rd_data and sets rd_valid=1 for exactly one cycle.
- Slave requirement: read data must be stable within CLK_DIV-1 clk cycles of the bus_clk rising edge.
- Write data stays on bus_data_out after the transfer; bus_data_oe stays 1 until a read turnaround.
- Back-to-back transfers:
  - IDLE lasts at least one cycle, so the minimum same-direction byte period is 2*CLK_DIV+1 clk cycles.
  - A command held valid is accepted on the first IDLE cycle.
- cmd_valid while cmd_ready=0 is ignored and not queued. cmd_data/cmd_rnw changes after accept have no effect.
- Status synchronizers:
  - done_sync and match_sync lag their inputs by 2 clk edges.
  - done_rise = done_sync & ~done_sync_d.
  - The synchronizers run independently of the FSM.
- Reset mid-transfer: the in-flight byte is abandoned and no rd_valid is produced. After release, the first transfer treats bus_rnw=0 as the current direction.
- bus_data_oe and bus_rnw are never both 1.

Test Plan:
- Reset: hold reset=0 with bus_done=1 -> all outputs 0 and cmd_ready=1; release -> done_sync=1 two edges later, with a single done_rise pulse.
- Single write, CLK_DIV=4: accept 0xA5 at E0 -> bus_data_out=0xA5, oe=1, rnw=0; bus_clk rises at E0+4 and falls at E0+8; cmd_ready=1 from E0+8; no rd_valid.
- Write then read, TURN_CYCLES=4:
  - After the write, accept a read at E0 -> oe=0 at E0, rnw=1 at E0+4, bus_clk rises at E0+8.
  - Slave model drives 0x3C -> rd_data=0x3C with a single rd_valid at E0+12.
  - oe and rnw are never both 1.
- Back-to-back: cmd_valid held for writes 0x01, 0x02, 0x03 -> exactly 3 bus_clk rising edges, 9 clk apart, carrying bytes 0x01, 0x02, 0x03 in order.
- Ignore while busy: toggle cmd_data/cmd_rnw during HIGH -> the transfer completes with the originally latched byte and direction.
- Reset during read HIGH -> bus_clk=0 and oe=0 immediately; no rd_valid after release; a following write is issued with no turnaround.

Source files
------------

// File: rtl/par8_master.sv
// -----------------------------------------------------------------------------
// par8_master
//   Master end of the 8-bit parallel bus. Takes single-byte read/write
//   commands from a host and runs each one as a full bus_clk period. Each
//   bus_clk half-period is CLK_DIV clk cycles long. When the bus direction
//   changes, TURN_CYCLES idle cycles are inserted first, so that the master
//   and the slave never drive bus_data at the same time. The slave status
//   lines bus_done and bus_match are synchronized into the clk domain.
//
// Ports
//   clk           in   system clock
//   reset         in   asynchronous reset, active low
//   cmd_valid     in   host command present
//   cmd_rnw       in   1 = read one byte, 0 = write cmd_data
//   cmd_data      in   [7:0] write byte
//   cmd_ready     out  command accepted when cmd_valid & cmd_ready (state IDLE)
//   rd_data       out  [7:0] byte captured on a read
//   rd_valid      out  one-cycle pulse that qualifies rd_data
//   busy          out  high while a transfer or turnaround is in progress
//   bus_clk       out  bus strobe
//   bus_rnw       out  bus direction, from the master's point of view
//   bus_data_out  out  [7:0] master write data
//   bus_data_oe   out  tri-state enable for bus_data_out
//   bus_data_in   in   [7:0] slave-driven data
//   bus_done      in   asynchronous status from the slave
//   bus_match     in   asynchronous status from the slave
//   done_sync     out  bus_done after a 2-flop synchronizer
//   match_sync    out  bus_match after a 2-flop synchronizer
//   done_rise     out  one-cycle pulse on a 0->1 transition of done_sync
// -----------------------------------------------------------------------------
module par8_master #(
  parameter int CLK_DIV     = 4,
  parameter int TURN_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic       cmd_rnw,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       bus_clk,
  output logic       bus_rnw,
  output logic [7:0] bus_data_out,
  output logic       bus_data_oe,
  input  logic [7:0] bus_data_in,
  input  logic       bus_done,
  input  logic       bus_match,
  output logic       done_sync,
  output logic       match_sync,
  output logic       done_rise
);

  // The counter is loaded with (length - 1), so it only has to hold MAXC-1.
  localparam int MAXC = (CLK_DIV > TURN_CYCLES) ? CLK_DIV : TURN_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] LP_DIV_LOAD  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LP_TURN_LOAD = CW'(TURN_CYCLES - 1);
  localparam logic [CW-1:0] LP_ZERO      = CW'(0);
  localparam logic [CW-1:0] LP_ONE       = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TURN = 2'd1,
    S_LOW  = 2'd2,
    S_HIGH = 2'd3
  } state_t;

  state_t          r_state,  w_state_nxt;
  logic [CW-1:0]   r_cnt,    w_cnt_nxt;
  logic            r_rnw_lat, w_rnw_lat_nxt;
  logic [7:0]      r_byte_lat, w_byte_lat_nxt;
  logic            r_bus_clk, w_bus_clk_nxt;
  logic            r_bus_rnw, w_bus_rnw_nxt;
  logic [7:0]      r_bus_data_out, w_bus_data_out_nxt;
  logic            r_bus_oe, w_bus_oe_nxt;
  logic [7:0]      r_rd_data, w_rd_data_nxt;
  logic            r_rd_valid, w_rd_valid_nxt;
  logic            r_busy, w_busy_nxt;

  logic            r_done_meta, r_done_sync, r_done_rise;
  logic            r_match_meta, r_match_sync;

  // Next-state and next-output logic for the transfer FSM.
  always_comb begin
    w_state_nxt        = r_state;
    w_cnt_nxt          = r_cnt;
    w_rnw_lat_nxt      = r_rnw_lat;
    w_byte_lat_nxt     = r_byte_lat;
    w_bus_clk_nxt      = r_bus_clk;
    w_bus_rnw_nxt      = r_bus_rnw;
    w_bus_data_out_nxt = r_bus_data_out;
    w_bus_oe_nxt       = r_bus_oe;
    w_rd_data_nxt      = r_rd_data;
    w_rd_valid_nxt     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_rnw_lat_nxt  = cmd_rnw;
          w_byte_lat_nxt = cmd_data;
          if (cmd_rnw == r_bus_rnw) begin
            w_state_nxt = S_LOW;
            w_cnt_nxt   = LP_DIV_LOAD;
            if (!cmd_rnw) begin
              w_bus_data_out_nxt = cmd_data;
              w_bus_oe_nxt       = 1'b1;
            end else begin
              w_bus_oe_nxt = 1'b0;
            end
          end else begin
            // Release whichever side currently owns the bus before turning.
            w_state_nxt = S_TURN;
            w_cnt_nxt   = LP_TURN_LOAD;
            if (cmd_rnw) begin
              w_bus_oe_nxt = 1'b0;
            end else begin
              w_bus_rnw_nxt = 1'b0;
            end
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_TURN: begin
        if (r_cnt == LP_ZERO) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = LP_DIV_LOAD;
          if (r_rnw_lat) begin
            w_bus_rnw_nxt = 1'b1;
          end else begin
            w_bus_data_out_nxt = r_byte_lat;
            w_bus_oe_nxt       = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - LP_ONE;
        end
      end

      S_LOW: begin
        if (r_cnt == LP_ZERO) begin
          w_state_nxt   = S_HIGH;
          w_cnt_nxt     = LP_DIV_LOAD;
          w_bus_clk_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - LP_ONE;
        end
      end

      S_HIGH: begin
        if (r_cnt == LP_ZERO) begin
          w_state_nxt   = S_IDLE;
          w_bus_clk_nxt = 1'b0;
          if (r_rnw_lat) begin
            // The slave has had CLK_DIV-1 cycles since the rising edge to settle.
            w_rd_data_nxt  = bus_data_in;
            w_rd_valid_nxt = 1'b1;
          end else begin
            w_rd_valid_nxt = 1'b0;
          end
        end else begin
          w_cnt_nxt = r_cnt - LP_ONE;
        end
      end

      default: begin
        w_state_nxt   = S_IDLE;
        w_cnt_nxt     = LP_ZERO;
        w_bus_clk_nxt = 1'b0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // FSM state, counter and registered bus/host outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= LP_ZERO;
      r_rnw_lat      <= 1'b0;
      r_byte_lat     <= 8'h00;
      r_bus_clk      <= 1'b0;
      r_bus_rnw      <= 1'b0;
      r_bus_data_out <= 8'h00;
      r_bus_oe       <= 1'b0;
      r_rd_data      <= 8'h00;
      r_rd_valid     <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_rnw_lat      <= w_rnw_lat_nxt;
      r_byte_lat     <= w_byte_lat_nxt;
      r_bus_clk      <= w_bus_clk_nxt;
      r_bus_rnw      <= w_bus_rnw_nxt;
      r_bus_data_out <= w_bus_data_out_nxt;
      r_bus_oe       <= w_bus_oe_nxt;
      r_rd_data      <= w_rd_data_nxt;
      r_rd_valid     <= w_rd_valid_nxt;
      r_busy         <= w_busy_nxt;
    end
  end

  // Status synchronizers, independent of the FSM. done_rise is registered so
  // that it goes high in the same cycle as the first high cycle of done_sync.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_done_meta  <= 1'b0;
      r_done_sync  <= 1'b0;
      r_done_rise  <= 1'b0;
      r_match_meta <= 1'b0;
      r_match_sync <= 1'b0;
    end else begin
      r_done_meta  <= bus_done;
      r_done_sync  <= r_done_meta;
      r_done_rise  <= r_done_meta & ~r_done_sync;
      r_match_meta <= bus_match;
      r_match_sync <= r_match_meta;
    end
  end

  assign cmd_ready    = (r_state == S_IDLE);
  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;
  assign busy         = r_busy;
  assign bus_clk      = r_bus_clk;
  assign bus_rnw      = r_bus_rnw;
  assign bus_data_out = r_bus_data_out;
  assign bus_data_oe  = r_bus_oe;
  assign done_sync    = r_done_sync;
  assign match_sync   = r_match_sync;
  assign done_rise    = r_done_rise;

endmodule

// File: tb/tb_par8_master.sv
// -----------------------------------------------------------------------------
// tb_par8_master
//   Directed bench for par8_master with CLK_DIV=4 and TURN_CYCLES=4.
//   Edge E0 is the clk edge that accepts a command. Inputs are driven 1 time
//   unit after a rising edge, and outputs are checked at the same point.
// -----------------------------------------------------------------------------
module tb_par8_master;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_rnw;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       bus_clk;
  logic       bus_rnw;
  logic [7:0] bus_data_out;
  logic       bus_data_oe;
  logic [7:0] bus_data_in;
  logic       bus_done;
  logic       bus_match;
  logic       done_sync;
  logic       match_sync;
  logic       done_rise;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state, written only by the negedge monitor.
  int   cyc = 0;
  int   excl_viol = 0;
  int   rdv_cnt = 0;
  int   rise_cnt = 0;
  int   rise_t [32];
  logic [7:0] rise_b [32];
  logic bus_clk_prev = 1'b0;

  par8_master #(.CLK_DIV(4), .TURN_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_rnw      (cmd_rnw),
    .cmd_data     (cmd_data),
    .cmd_ready    (cmd_ready),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .busy         (busy),
    .bus_clk      (bus_clk),
    .bus_rnw      (bus_rnw),
    .bus_data_out (bus_data_out),
    .bus_data_oe  (bus_data_oe),
    .bus_data_in  (bus_data_in),
    .bus_done     (bus_done),
    .bus_match    (bus_match),
    .done_sync    (done_sync),
    .match_sync   (match_sync),
    .done_rise    (done_rise)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Watches oe/rnw exclusivity, rd_valid pulses and bus_clk rising edges.
  always @(negedge clk) begin
    if (bus_data_oe && bus_rnw) excl_viol = excl_viol + 1;
    if (rd_valid) rdv_cnt = rdv_cnt + 1;
    if (bus_clk && !bus_clk_prev) begin
      if (rise_cnt < 32) begin
        rise_t[rise_cnt] = cyc;
        rise_b[rise_cnt] = bus_data_out;
      end
      rise_cnt = rise_cnt + 1;
    end
    bus_clk_prev = bus_clk;
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int base_rise;
  int base_rdv;
  int accepted;
  logic will_acc;
  logic idle_seen;

  initial begin
    reset       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_rnw     = 1'b0;
    cmd_data    = 8'h00;
    bus_data_in = 8'h00;
    bus_done    = 1'b1;
    bus_match   = 1'b0;

    // ---------------- reset state ----------------
    tick(2);
    chk_val("rst_bus_clk",  {31'd0, bus_clk},     32'd0);
    chk_val("rst_rnw_oe",   {30'd0, bus_rnw, bus_data_oe}, 32'd0);
    chk_val("rst_data_out", {24'd0, bus_data_out}, 32'd0);
    chk_val("rst_rd",       {23'd0, rd_valid, rd_data}, 32'd0);
    chk_val("rst_busy",     {31'd0, busy},        32'd0);
    chk_val("rst_sync",     {29'd0, done_sync, match_sync, done_rise}, 32'd0);
    chk_val("rst_cmd_ready",{31'd0, cmd_ready},   32'd1);

    reset = 1'b1;
    tick(1);
    chk_val("done_sync_e1", {30'd0, done_sync, done_rise}, 32'd0);
    tick(1);
    chk_val("done_sync_e2", {30'd0, done_sync, done_rise}, 32'd3);
    bus_match = 1'b1;
    tick(1);
    chk_val("done_rise_e3", {30'd0, done_sync, done_rise}, 32'd2);
    chk_val("match_lag1",   {31'd0, match_sync}, 32'd0);
    tick(1);
    chk_val("match_lag2",   {31'd0, match_sync}, 32'd1);

    // ---------------- single write 0xA5 ----------------
    base_rdv  = rdv_cnt;
    cmd_valid = 1'b1; cmd_rnw = 1'b0; cmd_data = 8'hA5;
    tick(1); // E0
    cmd_valid = 1'b0;
    chk_val("wr_e0_data",   {24'd0, bus_data_out}, 32'h0000_00A5);
    chk_val("wr_e0_oe_rnw", {30'd0, bus_data_oe, bus_rnw}, 32'd2);
    chk_val("wr_e0_busy",   {30'd0, busy, cmd_ready}, 32'd2);
    tick(3); // E0+3
    chk_val("wr_e3_clk",    {31'd0, bus_clk}, 32'd0);
    tick(1); // E0+4
    chk_val("wr_e4_clk",    {31'd0, bus_clk}, 32'd1);
    tick(3); // E0+7
    chk_val("wr_e7_clk_rdy",{30'd0, bus_clk, cmd_ready}, 32'd2);
    tick(1); // E0+8
    chk_val("wr_e8_clk_rdy",{30'd0, bus_clk, cmd_ready}, 32'd1);
    chk_val("wr_e8_busy",   {31'd0, busy}, 32'd0);
    chk_val("wr_no_rdvalid", rdv_cnt - base_rdv, 32'd0);
    chk_val("wr_data_kept", {23'd0, bus_data_oe, bus_data_out}, 32'h0000_01A5);

    // ---------------- write -> read turnaround, slave drives 0x3C ----------------
    bus_data_in = 8'h3C;
    cmd_valid = 1'b1; cmd_rnw = 1'b1; cmd_data = 8'h00;
    tick(1); // E0
    cmd_valid = 1'b0;
    chk_val("rd_e0_oe_rnw", {30'd0, bus_data_oe, bus_rnw}, 32'd0);
    tick(3); // E0+3
    chk_val("rd_e3_rnw",    {31'd0, bus_rnw}, 32'd0);
    tick(1); // E0+4
    chk_val("rd_e4_rnw_clk",{30'd0, bus_rnw, bus_clk}, 32'd2);
    tick(3); // E0+7
    chk_val("rd_e7_clk",    {31'd0, bus_clk}, 32'd0);
    tick(1); // E0+8
    chk_val("rd_e8_clk",    {31'd0, bus_clk}, 32'd1);
    tick(3); // E0+11
    chk_val("rd_e11_valid", {31'd0, rd_valid}, 32'd0);
    tick(1); // E0+12
    chk_val("rd_e12_valid", {31'd0, rd_valid}, 32'd1);
    chk_val("rd_e12_data",  {24'd0, rd_data}, 32'h0000_003C);
    chk_val("rd_e12_clk",   {31'd0, bus_clk}, 32'd0);
    tick(1); // E0+13
    chk_val("rd_e13_valid", {31'd0, rd_valid}, 32'd0);
    chk_val("rd_pulse_cnt", rdv_cnt - base_rdv, 32'd1);

    // ---------------- back-to-back writes with cmd_valid held ----------------
    base_rise = rise_cnt;
    accepted  = 0;
    cmd_valid = 1'b1; cmd_rnw = 1'b0; cmd_data = 8'h01;
    for (int k = 0; k < 200 && accepted < 3; k++) begin
      will_acc = cmd_ready;
      tick(1);
      if (will_acc) begin
        accepted = accepted + 1;
        cmd_data = 8'(accepted + 1);
      end
    end
    cmd_valid = 1'b0;
    chk_val("b2b_accepts", accepted, 32'd3);
    idle_seen = 1'b0;
    for (int k = 0; k < 100 && !idle_seen; k++) begin
      tick(1);
      if (!busy) idle_seen = 1'b1;
    end
    chk_val("b2b_idle", {31'd0, idle_seen}, 32'd1);
    tick(2);
    chk_val("b2b_rises", rise_cnt - base_rise, 32'd3);
    if (rise_cnt - base_rise == 3) begin
      chk_val("b2b_byte0", {24'd0, rise_b[base_rise]},     32'h01);
      chk_val("b2b_byte1", {24'd0, rise_b[base_rise + 1]}, 32'h02);
      chk_val("b2b_byte2", {24'd0, rise_b[base_rise + 2]}, 32'h03);
      chk_val("b2b_gap01", rise_t[base_rise + 1] - rise_t[base_rise],     32'd9);
      chk_val("b2b_gap12", rise_t[base_rise + 2] - rise_t[base_rise + 1], 32'd9);
    end

    // ---------------- inputs changed while busy are ignored ----------------
    base_rise = rise_cnt;
    base_rdv  = rdv_cnt;
    cmd_valid = 1'b1; cmd_rnw = 1'b0; cmd_data = 8'h5A;
    tick(1); // E0
    cmd_valid = 1'b0;
    tick(5); // E0+5, in HIGH
    cmd_valid = 1'b1; cmd_rnw = 1'b1; cmd_data = 8'hFF;
    tick(2); // E0+7
    cmd_valid = 1'b0;
    tick(1); // E0+8
    chk_val("ign_data",     {24'd0, bus_data_out}, 32'h0000_005A);
    chk_val("ign_dir",      {30'd0, bus_data_oe, bus_rnw}, 32'd2);
    tick(1); // E0+9
    chk_val("ign_no_queue", {31'd0, busy}, 32'd0);
    chk_val("ign_no_rd",    rdv_cnt - base_rdv, 32'd0);
    chk_val("ign_rise_byte",{24'd0, rise_b[base_rise]}, 32'h0000_005A);

    // ---------------- reset during read HIGH ----------------
    base_rdv    = rdv_cnt;
    bus_data_in = 8'h77;
    cmd_valid = 1'b1; cmd_rnw = 1'b1; cmd_data = 8'h00;
    tick(1); // E0, turnaround write->read
    cmd_valid = 1'b0;
    tick(10); // E0+10, in HIGH
    chk_val("mid_in_high",  {30'd0, bus_clk, bus_rnw}, 32'd3);
    reset = 1'b0;
    #1;
    chk_val("mid_rst_clk_oe", {29'd0, bus_clk, bus_data_oe, bus_rnw}, 32'd0);
    chk_val("mid_rst_busy", {30'd0, busy, cmd_ready}, 32'd1);
    tick(2);
    reset = 1'b1;
    tick(20);
    chk_val("mid_no_rdvalid", rdv_cnt - base_rdv, 32'd0);
    cmd_valid = 1'b1; cmd_rnw = 1'b0; cmd_data = 8'h99;
    tick(1); // E0
    cmd_valid = 1'b0;
    chk_val("post_wr_e0",   {22'd0, busy, bus_data_oe, bus_data_out}, 32'h0000_0399);
    tick(4); // E0+4, rises with no turnaround
    chk_val("post_wr_e4",   {31'd0, bus_clk}, 32'd1);
    tick(4); // E0+8
    chk_val("post_wr_e8",   {30'd0, bus_clk, cmd_ready}, 32'd1);

    chk_val("oe_rnw_excl",  excl_viol, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
